fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch and realignment stage feeding the decoder. Issues word reads to instruction
//  memory, buffers returned words in a small FIFO, and extracts one 16- or 32-bit instruction per
//  handshake at any halfword-aligned PC. Instructions straddling a word boundary are supported.
//  Presents instr_o/instr_addr_o to the decoder; flushes and restarts on jump/branch redirect.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  PC fetched first after reset (halfword aligned)
//  FIFO_DEPTH  2              fetched-word buffer entries (>=2, power of two)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   synchronous reset, active-high
//  imem_req_o       out  1   word read request
//  imem_addr_o      out  32  read address, bits[1:0]=0
//  imem_gnt_i       in   1   request accepted this cycle
//  imem_rvalid_i    in   1   read data valid (>=1 cycle after gnt)
//  imem_rdata_i     in   32  read data
//  redirect_i       in   1   PC redirect (jump/taken branch)
//  redirect_addr_i  in   32  new PC, bit0 ignored (treated as 0)
//  instr_o          out  32  instruction; compressed = {16'h0, half}
//  instr_addr_o     out  32  PC of instr_o
//  instr_valid_o    out  1   instr_o/instr_addr_o valid
//  instr_ready_i    in   1   decoder consumes instr_o this cycle
// BEHAVIOUR
//  Reset (rst=1 at edge): FIFO empty, PC=fetch_addr=RESET_ADDR, FSM=REQ, discard=0; outputs
//   imem_req_o=0, imem_addr_o={RESET_ADDR[31:2],2'b0}, instr_valid_o=0, instr_o=0,
//   instr_addr_o=RESET_ADDR. Reset mid-transaction drops any outstanding response.
//  Fetch FSM (one outstanding read max):
//   REQ : imem_req_o=1 iff FIFO free slots > 0; stay until gnt. On gnt -> WAIT, fetch_addr+=4.
//   WAIT: imem_req_o=0. On rvalid: push {rdata} unless discard (then clear discard, no push) -> REQ.
//   Address/req stable while req=1 and gnt=0.
//  FIFO push happens same edge as rvalid; pop and push in the same cycle allowed when full.
//  Aligner (combinational from FIFO head, registered nowhere else):
//   PC[1]=0: half=head[15:0]; half[1:0]!=2'b11 -> 16-bit, else 32-bit = head word.
//   PC[1]=1: half=head[31:16]; compressed needs head only; 32-bit needs 2 entries,
//            instr={next[15:0], head[31:16]}.
//   instr_valid_o=1 when required entries present and no redirect this cycle.
//  Consume (valid & ready): PC += 2 or 4; pop head when the instruction ends at or beyond its upper
//   half (i.e. new PC crosses a word boundary). A straddling 32-bit pops one entry.
//  Redirect (highest priority, overrides same-cycle consume): FIFO flushed, PC=redirect_addr&~1,
//   fetch_addr=redirect_addr&~3. If in WAIT -> discard=1 (pending response dropped), else REQ
//   re-issues next cycle with new address; a request held ungranted switches address.
//   instr_valid_o=0 in the redirect cycle. Redirect during discard keeps discard=1.
//  Latency: gnt at cycle N, rvalid at N+1 -> instr_valid_o=1 at N+2.
//  Address arithmetic wraps modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//  Empty FIFO: instr_valid_o=0, instr_o holds last value. Full FIFO: imem_req_o=0.
// TESTING
//  Reset then 32-bit words 0x00500093, 0x00108113 with gnt=1, rvalid one cycle later
//   -> instr_addr_o 0x0, 0x4 in order, instr_o matches words, first valid 3 cycles after reset release.
//  Word 0x4505_0505 at PC 0 -> two compressed instrs 0x00000505 @0, 0x00004505 @2, then fetch @4.
//  Redirect to 0x102; words @0x100=0x0093_0001, @0x104=0x0000_0050 -> instr 0x00500093 @0x102 after
//   both words arrive; valid never asserts with one entry.
//  Redirect while in WAIT -> stale rvalid data never appears on instr_o; next req addr = new target.
//  instr_ready_i=0 for 10 cycles -> FIFO fills, imem_req_o drops to 0, no data lost, order preserved.
//  rst asserted mid-WAIT -> outputs return to reset values; next fetch from RESET_ADDR.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, the instruction memory port and the decoder.
// master = fetch stage side; slave = memory/decoder side.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, instr_addr_o, instr_valid_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_addr_i,
               instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, instr_addr_o, instr_valid_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_addr_i,
               instr_ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + realignment: one outstanding word read, a small word FIFO,
// and an aligner that extracts 16/32-bit instructions at any halfword PC.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus_io
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {S_REQ, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   pc_q, pc_d;
    logic          discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   last_instr_q, last_instr_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic [PW-1:0] rd_nxt;
    logic [31:0]   head, nxt, aligned;
    logic [15:0]   half;
    logic          is_comp, need_two, have;
    logic          redir, req, accept, push, pop, valid, consume;

    // Aligner: everything is decoded straight from the FIFO head and the entry behind it.
    always_comb begin
        rd_nxt   = rd_ptr_q + PW'(1);
        head     = mem_q[rd_ptr_q];
        nxt      = mem_q[rd_nxt];
        half     = pc_q[1] ? head[31:16] : head[15:0];
        is_comp  = (half[1:0] != 2'b11);
        need_two = pc_q[1] & ~is_comp;
        have     = need_two ? (cnt_q >= CW'(2)) : (cnt_q != '0);
        if (is_comp) begin
            aligned = {16'h0000, half};
        end else if (pc_q[1]) begin
            aligned = {nxt[15:0], head[31:16]};
        end else begin
            aligned = head;
        end
    end

    assign redir   = bus_io.redirect_i;
    assign req     = (state_q == S_REQ) && (cnt_q < CW'(FIFO_DEPTH)) && !rst;
    assign accept  = req & bus_io.imem_gnt_i;
    assign push    = (state_q == S_WAIT) & bus_io.imem_rvalid_i & ~discard_q & ~redir;
    assign valid   = have & ~redir;
    assign consume = valid & bus_io.instr_ready_i;
    // A consumed instruction leaves its word when it starts in the upper half or is 32-bit.
    assign pop     = consume & (pc_q[1] | ~is_comp);

    assign bus_io.imem_req_o    = req;
    assign bus_io.imem_addr_o   = fetch_addr_q;
    assign bus_io.instr_valid_o = valid;
    assign bus_io.instr_o       = have ? aligned : last_instr_q;
    assign bus_io.instr_addr_o  = pc_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        discard_d    = discard_q;
        unique case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d      = S_WAIT;
                    fetch_addr_d = fetch_addr_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (bus_io.imem_rvalid_i) begin
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                end
            end
            default: state_d = S_REQ;
        endcase
        // A read still in flight after the redirect edge belongs to the old path.
        if (redir) begin
            fetch_addr_d = bus_io.redirect_addr_i & 32'hFFFF_FFFC;
            if (((state_q == S_WAIT) && !bus_io.imem_rvalid_i) ||
                ((state_q == S_REQ) && accept)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        last_instr_d = have ? aligned : last_instr_q;
        if (redir) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            pc_d     = bus_io.redirect_addr_i & 32'hFFFF_FFFE;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_nxt;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            if (consume) begin
                pc_d = pc_q + (is_comp ? 32'd2 : 32'd4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_addr_q <= RESET_ADDR & 32'hFFFF_FFFC;
            pc_q         <= RESET_ADDR;
            discard_q    <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            last_instr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            last_instr_q <= last_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_io.imem_rdata_i;
        end
    end
endmodule
